huffman_packer: RTL

Downstream stage of the Huffman encoder. Latches the six-entry code table (HC1–HC6 / M1–M6) when `code_valid` pulses, then accepts a replayed stream of gray symbols 1..6 and emits the concatenated variable-length codes as a packed MSB-first byte stream with valid/ready flow control. A frame ends on `sym_last`; the final byte is zero-padded and flagged with `out_last`.

---
 rtl/huffman_packer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/huffman_packer.sv
// ============================================================================
// Module   : huffman_packer
// Purpose  : Packs variable-length Huffman codes, MSB first, into a byte stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module huffman_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        code_valid,
   input  logic [7:0]  HC1,
   input  logic [7:0]  HC2,
   input  logic [7:0]  HC3,
   input  logic [7:0]  HC4,
   input  logic [7:0]  HC5,
   input  logic [7:0]  HC6,
   input  logic [7:0]  M1,
   input  logic [7:0]  M2,
   input  logic [7:0]  M3,
   input  logic [7:0]  M4,
   input  logic [7:0]  M5,
   input  logic [7:0]  M6,
   input  logic        sym_valid,
   input  logic [7:0]  sym_data,
   input  logic        sym_last,
   output logic        sym_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_last,
   input  logic        out_ready,
   output logic        err,
   output logic [15:0] bytes_out
);

   typedef enum logic [1:0] {
      S_WAIT_TBL = 2'd0,
      S_RUN      = 2'd1,
      S_FLUSH    = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [7:0]  r_hc [0:5];
   logic [7:0]  r_m  [0:5];
   logic [15:0] r_acc;
   logic [4:0]  r_cnt;
   logic        r_out_valid;
   logic [7:0]  r_out_data;
   logic        r_out_last;
   logic        r_err;
   logic [15:0] r_bytes_out;

   logic [7:0]  w_sel_hc;
   logic [7:0]  w_sel_m;
   logic        w_sym_ok;
   logic [3:0]  w_len;
   logic        w_bad;
   logic [4:0]  w_shamt;
   logic [15:0] w_ins;
   logic        w_accept;
   logic        w_slot_free;
   logic        w_out_hs;
   logic        w_emit_byte;
   logic        w_emit_last;
   logic        w_tbl_load;

   always_comb begin
      w_sel_hc = 8'h00;
      w_sel_m  = 8'h00;
      w_sym_ok = 1'b1;
      case (sym_data)
         8'd1:    begin w_sel_hc = r_hc[0]; w_sel_m = r_m[0]; end
         8'd2:    begin w_sel_hc = r_hc[1]; w_sel_m = r_m[1]; end
         8'd3:    begin w_sel_hc = r_hc[2]; w_sel_m = r_m[2]; end
         8'd4:    begin w_sel_hc = r_hc[3]; w_sel_m = r_m[3]; end
         8'd5:    begin w_sel_hc = r_hc[4]; w_sel_m = r_m[4]; end
         8'd6:    begin w_sel_hc = r_hc[5]; w_sel_m = r_m[5]; end
         default: w_sym_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_len = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_len = w_len + {3'b000, w_sel_m[i]};
      end
   end

   // New code lands directly below the r_cnt bits already held at the top.
   assign w_bad       = !w_sym_ok || (w_sel_m == 8'h00);
   assign w_shamt     = 5'd16 - r_cnt - {1'b0, w_len};
   assign w_ins       = {8'h00, w_sel_hc & w_sel_m} << w_shamt;
   assign w_accept    = sym_valid && sym_ready;
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_out_hs    = r_out_valid && out_ready;
   assign w_tbl_load  = code_valid && (r_state != S_FLUSH);

   assign w_emit_byte = w_slot_free &&
                        (((r_state == S_RUN) && (r_cnt >= 5'd8)) ||
                         ((r_state == S_FLUSH) && (r_cnt > 5'd8)));
   // A pending final byte must not be re-emitted while it waits for a handshake.
   assign w_emit_last = w_slot_free && (r_state == S_FLUSH) && (r_cnt <= 5'd8) &&
                        !(r_out_valid && r_out_last);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_WAIT_TBL;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      sym_ready   = 1'b0;
      case (r_state)
         S_WAIT_TBL: begin
            if (code_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            sym_ready = (r_cnt <= 5'd7);
            if (sym_valid && (r_cnt <= 5'd7) && sym_last) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (w_out_hs && r_out_last) w_state_nxt = S_WAIT_TBL;
         end
         default: w_state_nxt = S_WAIT_TBL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 6; i++) begin
            r_hc[i] <= 8'h00;
            r_m[i]  <= 8'h00;
         end
         r_acc       <= 16'h0000;
         r_cnt       <= 5'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_last  <= 1'b0;
         r_err       <= 1'b0;
         r_bytes_out <= 16'h0000;
      end else begin
         if (w_tbl_load) begin
            r_hc[0] <= HC1; r_hc[1] <= HC2; r_hc[2] <= HC3;
            r_hc[3] <= HC4; r_hc[4] <= HC5; r_hc[5] <= HC6;
            r_m[0]  <= M1;  r_m[1]  <= M2;  r_m[2]  <= M3;
            r_m[3]  <= M4;  r_m[4]  <= M5;  r_m[5]  <= M6;
         end

         if ((r_state == S_WAIT_TBL) && code_valid) r_bytes_out <= 16'h0000;
         else if (w_out_hs)                         r_bytes_out <= r_bytes_out + 16'd1;

         if ((r_state == S_WAIT_TBL) && code_valid) r_err <= 1'b0;
         else if (w_accept && w_bad)                r_err <= 1'b1;

         if (w_accept && !w_bad) begin
            r_acc <= r_acc | w_ins;
            r_cnt <= r_cnt + {1'b0, w_len};
         end else if (w_emit_byte) begin
            r_acc <= {r_acc[7:0], 8'h00};
            r_cnt <= r_cnt - 5'd8;
         end else if (w_emit_last) begin
            r_acc <= 16'h0000;
            r_cnt <= 5'd0;
         end

         if (w_emit_byte || w_emit_last) begin
            r_out_data  <= r_acc[15:8];
            r_out_valid <= 1'b1;
            r_out_last  <= w_emit_last;
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign err       = r_err;
   assign bytes_out = r_bytes_out;

endmodule

`default_nettype wire
